stall_fwd_ctrl: RTL

STALL_FWD_CTRL -- requirements
Module: stall_fwd_ctrl

---
 rtl/stall_fwd_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/stall_fwd_ctrl.sv
// Hazard unit: tuse/tnew stall detection plus D/E/M operand forwarding selects.
// Define STALL_FWD_CTRL_FWD_EN for forwarding; otherwise stall-only mode.
module stall_fwd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_a1,
    input  logic [4:0] d_a2,
    input  logic [4:0] d_a3,
    input  logic       d_we,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic       flush_e,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic       we;
        logic [1:0] tnew;
    } rec_t;

    rec_t e_r, m_r, w_r;

    function automatic logic hit(input logic [4:0] r, input rec_t x);
        return x.we && (x.a3 == r) && (r != 5'd0);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= '0;
            m_r <= '0;
            w_r <= '0;
        end else begin
            if (stall)
                e_r <= '0;
            else
                e_r <= '{a1: d_a1, a2: d_a2, a3: d_a3, we: d_we, tnew: d_tnew};
            m_r      <= e_r;
            m_r.tnew <= (e_r.tnew == 2'd0) ? 2'd0 : e_r.tnew - 2'd1;
            w_r      <= m_r;
            w_r.tnew <= 2'd0;
        end
    end

`ifdef STALL_FWD_CTRL_FWD_EN
    // Stall only while the producer's result is still too far away.
    function automatic logic need_stall(input logic [4:0] r,
                                        input logic [1:0] tuse,
                                        input rec_t e, input rec_t m);
        return (tuse != 2'd3) &&
               ((hit(r, e) && (e.tnew > tuse)) ||
                (hit(r, m) && (m.tnew > tuse)));
    endfunction

    // Youngest matching stage wins; an unready youngest match selects none.
    function automatic logic [1:0] sel_d(input logic [4:0] r, input rec_t e,
                                         input rec_t m, input rec_t w);
        if (hit(r, e)) return (e.tnew == 2'd0) ? 2'b01 : 2'b00;
        if (hit(r, m)) return (m.tnew == 2'd0) ? 2'b10 : 2'b00;
        if (hit(r, w)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r, input rec_t m,
                                         input rec_t w);
        if (hit(r, m)) return (m.tnew == 2'd0) ? 2'b01 : 2'b00;
        if (hit(r, w)) return 2'b10;
        return 2'b00;
    endfunction

    assign stall    = need_stall(d_a1, d_tuse_rs, e_r, m_r) ||
                      need_stall(d_a2, d_tuse_rt, e_r, m_r);
    assign fwd_d_rs = sel_d(d_a1, e_r, m_r, w_r);
    assign fwd_d_rt = sel_d(d_a2, e_r, m_r, w_r);
    assign fwd_e_rs = sel_e(e_r.a1, m_r, w_r);
    assign fwd_e_rt = sel_e(e_r.a2, m_r, w_r);
    assign fwd_m_rt = hit(m_r.a2, w_r);

    logic unused;
    assign unused = ^{w_r.a1, w_r.a2, w_r.tnew};
`else
    // Without bypass paths any in-flight writer of a source blocks D.
    function automatic logic need_stall(input logic [4:0] r,
                                        input logic [1:0] tuse,
                                        input rec_t e, input rec_t m,
                                        input rec_t w);
        return (tuse != 2'd3) && (hit(r, e) || hit(r, m) || hit(r, w));
    endfunction

    assign stall    = need_stall(d_a1, d_tuse_rs, e_r, m_r, w_r) ||
                      need_stall(d_a2, d_tuse_rt, e_r, m_r, w_r);
    assign fwd_d_rs = 2'b00;
    assign fwd_d_rt = 2'b00;
    assign fwd_e_rs = 2'b00;
    assign fwd_e_rt = 2'b00;
    assign fwd_m_rt = 1'b0;

    logic unused;
    assign unused = ^{w_r.a1, w_r.a2, w_r.tnew, m_r.a2, m_r.tnew};
`endif

    assign flush_e = stall;

endmodule
